// File: rtl/systolic_mac_array.sv
// systolic_mac_array
//   Output-stationary N x N systolic matrix multiplier computing C = A x B.
//   PE(i,j) owns accumulator C[i][j]. Row i of A enters from the left and
//   column j of B enters from the top. Each is skewed by i or j enabled
//   cycles, so beat k meets PE(i,j) on enabled cycle k+i+j.
//   Job flow: IDLE -> LOAD -> FLUSH -> DRAIN -> IDLE. A zero-length job goes
//   straight from IDLE to DRAIN. N must be >= 2.
//
// Ports
//   clk       : clock, all state on the rising edge
//   reset     : asynchronous, active-low reset
//   start     : one-cycle job request, sampled only in IDLE
//   k_len     : beats per job, sampled with start, clamped to KMAX
//   acc_keep  : sampled with start; 1 = accumulate, 0 = clear accumulators
//   in_valid  : input beat valid
//   in_ready  : input beat ready (LOAD only)
//   a_vec     : column k of A, element i at [i*DW +: DW]
//   b_vec     : row k of B, element j at [j*DW +: DW]
//   out_valid : result row valid (DRAIN only)
//   out_ready : result row accepted
//   out_row   : row r of C, element j at [j*AW +: AW]
//   out_last  : high with out_valid on row N-1
//   busy      : high whenever not IDLE
module systolic_mac_array #(
  parameter int DW   = 8,
  parameter int N    = 4,
  parameter int KMAX = 16,
  parameter int AW   = 2*DW + $clog2(KMAX)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [$clog2(KMAX+1)-1:0] k_len,
  input  logic                      acc_keep,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N*DW-1:0]           a_vec,
  input  logic [N*DW-1:0]           b_vec,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N*AW-1:0]           out_row,
  output logic                      out_last,
  output logic                      busy
);

  localparam int KW = $clog2(KMAX+1);
  localparam int FW = $clog2(2*N);
  localparam int RW = $clog2(N);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [KW-1:0] klen_q;
  logic [KW-1:0] beat_cnt;
  logic [FW-1:0] flush_cnt;
  logic [RW-1:0] row;
  logic [RW-1:0] row_sel;
  logic          out_v;
  logic [KW-1:0] klen_clamped;
  logic          en, clr_pipe, clr_acc;
  logic          last_beat, flush_done, row_xfer;
  logic [N*AW-1:0] row_data;

  logic signed [DW-1:0]   a_src  [N];
  logic signed [DW-1:0]   b_src  [N];
  logic signed [DW-1:0]   a_edge [N];
  logic signed [DW-1:0]   b_edge [N];
  logic signed [DW-1:0]   pe_a   [N][N];
  logic signed [DW-1:0]   pe_b   [N][N];
  logic signed [DW-1:0]   a_pass [N][N];
  logic signed [DW-1:0]   b_pass [N][N];
  logic signed [2*DW-1:0] prod   [N][N];
  logic signed [AW-1:0]   acc    [N][N];

  // ---------------------------------------------------------------- control
  assign klen_clamped = (k_len > KW'(KMAX)) ? KW'(KMAX) : k_len;
  assign en         = ((state == LOAD) && in_valid) || (state == FLUSH);
  assign clr_pipe   = (state == IDLE) && start;
  assign clr_acc    = clr_pipe && !acc_keep;
  assign last_beat  = (state == LOAD) && in_valid && (beat_cnt == klen_q - KW'(1));
  assign flush_done = (state == FLUSH) && (flush_cnt == FW'(2*N-3));
  assign row_xfer   = out_v && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    out_last  = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (klen_clamped == '0) ? DRAIN : LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (last_beat) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (flush_done) state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = out_v;
        out_last  = out_v && (row == RW'(N-1));
        if (row_xfer && (row == RW'(N-1))) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The output row is registered, so DRAIN spends one cycle loading row 0
  // before out_valid rises; this gives the 2N-1 edge first-row latency.
  assign row_sel = out_v ? row + RW'(1) : row;

  always_comb begin
    row_data = '0;
    for (int unsigned j = 0; j < N; j++) begin
      row_data[j*AW +: AW] = acc[row_sel][j];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      klen_q    <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      row       <= '0;
      out_v     <= 1'b0;
      out_row   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            klen_q    <= klen_clamped;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            row       <= '0;
            out_v     <= 1'b0;
          end
        end
        LOAD: begin
          if (in_valid) beat_cnt <= beat_cnt + KW'(1);
        end
        FLUSH: begin
          flush_cnt <= flush_cnt + FW'(1);
        end
        DRAIN: begin
          if (!out_v) begin
            out_v   <= 1'b1;
            out_row <= row_data;
          end else if (out_ready) begin
            if (row == RW'(N-1)) begin
              out_v   <= 1'b0;
              row     <= '0;
              out_row <= '0;
            end else begin
              row     <= row + RW'(1);
              out_row <= row_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- skew
  // Zeros are injected once the job leaves LOAD so FLUSH drains the array.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      a_src[i] = (state == LOAD) ? a_vec[i*DW +: DW] : '0;
      b_src[i] = (state == LOAD) ? b_vec[i*DW +: DW] : '0;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_nodly
      assign a_edge[i] = a_src[i];
      assign b_edge[i] = b_src[i];
    end else begin : g_dly
      localparam int unsigned DEPTH = i;
      logic signed [DW-1:0] a_sk [DEPTH];
      logic signed [DW-1:0] b_sk [DEPTH];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int unsigned d = 0; d < DEPTH; d++) begin
            a_sk[d] <= '0;
            b_sk[d] <= '0;
          end
        end else if (clr_pipe) begin
          for (int unsigned d = 0; d < DEPTH; d++) begin
            a_sk[d] <= '0;
            b_sk[d] <= '0;
          end
        end else if (en) begin
          a_sk[0] <= a_src[i];
          b_sk[0] <= b_src[i];
          for (int unsigned d = 1; d < DEPTH; d++) begin
            a_sk[d] <= a_sk[d-1];
            b_sk[d] <= b_sk[d-1];
          end
        end
      end

      assign a_edge[i] = a_sk[DEPTH-1];
      assign b_edge[i] = b_sk[DEPTH-1];
    end
  end

  // ---------------------------------------------------------------- PE array
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      if (j == 0) begin : g_a_edge
        assign pe_a[i][j] = a_edge[i];
      end else begin : g_a_pass
        assign pe_a[i][j] = a_pass[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign pe_b[i][j] = b_edge[j];
      end else begin : g_b_pass
        assign pe_b[i][j] = b_pass[i-1][j];
      end
      assign prod[i][j] = (2*DW)'(pe_a[i][j]) * (2*DW)'(pe_b[i][j]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned j = 0; j < N; j++) begin
          acc[i][j]    <= '0;
          a_pass[i][j] <= '0;
          b_pass[i][j] <= '0;
        end
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned j = 0; j < N; j++) begin
          if (clr_pipe) begin
            a_pass[i][j] <= '0;
            b_pass[i][j] <= '0;
            if (clr_acc) acc[i][j] <= '0;
          end else if (en) begin
            acc[i][j]    <= acc[i][j] + AW'(prod[i][j]);
            a_pass[i][j] <= pe_a[i][j];
            b_pass[i][j] <= pe_b[i][j];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_mac_array.sv
// Self-checking bench for systolic_mac_array (N=4, DW=8, KMAX=16).
// Expected rows come from a plain matrix-product model that carries
// accumulator contents across jobs.
module tb_systolic_mac_array;

  localparam int DW   = 8;
  localparam int N    = 4;
  localparam int KMAX = 16;
  localparam int AW   = 2*DW + $clog2(KMAX);
  localparam int KW   = $clog2(KMAX+1);

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [KW-1:0]   k_len;
  logic            acc_keep;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] a_vec;
  logic [N*DW-1:0] b_vec;
  logic            out_valid;
  logic            out_ready;
  logic [N*AW-1:0] out_row;
  logic            out_last;
  logic            busy;

  systolic_mac_array #(.DW(DW), .N(N), .KMAX(KMAX)) dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len), .acc_keep(acc_keep),
    .in_valid(in_valid), .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // reference state: job operands and the accumulator matrix
  int     am [N][KMAX];
  int     bm [KMAX][N];
  longint mc [N][N];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_identity();
    for (int k = 0; k < KMAX; k++)
      for (int i = 0; i < N; i++) begin
        am[i][k] = (i == k) ? 1 : 0;
        bm[k][i] = (k < N) ? 4*k + i + 1 : 0;
      end
  endtask

  task automatic load_const(input int av, input int bv);
    for (int k = 0; k < KMAX; k++)
      for (int i = 0; i < N; i++) begin
        am[i][k] = av;
        bm[k][i] = bv;
      end
  endtask

  task automatic load_random();
    for (int k = 0; k < KMAX; k++)
      for (int i = 0; i < N; i++) begin
        am[i][k] = int'($urandom_range(0, 255)) - 128;
        bm[k][i] = int'($urandom_range(0, 255)) - 128;
      end
  endtask

  task automatic drive_beat(input int k);
    for (int i = 0; i < N; i++) begin
      a_vec[i*DW +: DW] = DW'(am[i][k]);
      b_vec[i*DW +: DW] = DW'(bm[k][i]);
    end
  endtask

  // gap_mode: 0 = in_valid always high, 1 = toggle every cycle, 2 = random
  task automatic run_job(input int kl, input bit keep, input int gap_mode,
                         input int stall_row, input int stall_cyc,
                         input bit mid_start, input string name);
    int beats, k, guard, last_edge, nstall;
    bit tog, iv;
    logic [N*AW-1:0] exp_row, held;

    beats = (kl > KMAX) ? KMAX : kl;
    if (!keep)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) mc[i][j] = 0;
    for (int kk = 0; kk < beats; kk++)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          mc[i][j] += longint'(am[i][kk]) * longint'(bm[kk][j]);

    @(negedge clk);
    start = 1'b1; k_len = KW'(kl); acc_keep = keep;
    @(negedge clk);
    start = 1'b0; acc_keep = ~keep; k_len = KW'($urandom_range(0, 20));
    check({name, "_busy"}, busy, 1'b1);

    k = 0; guard = 0; tog = 1'b1; last_edge = 0;
    while (k < beats && guard < 500) begin
      iv = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      in_valid = iv;
      drive_beat(k);
      if (mid_start && k == 2) begin
        start = 1'b1; k_len = '0; acc_keep = 1'b0;
      end else begin
        start = 1'b0;
      end
      if (iv && in_ready) begin
        if (k == beats - 1) last_edge = int'(cyc) + 1;
        k++;
      end
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    if (k < beats) check({name, "_load_timeout"}, k, beats);

    // junk beats outside LOAD must be refused
    in_valid = 1'b1;
    a_vec = N*DW'($urandom); b_vec = N*DW'($urandom);
    if (beats > 0) check({name, "_ready_after_load"}, in_ready, 1'b0);

    guard = 0;
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!out_valid) begin
      check({name, "_valid_timeout"}, out_valid, 1'b1);
      in_valid = 1'b0;
      return;
    end
    if (beats > 0) check({name, "_latency"}, int'(cyc) - last_edge, 2*N-1);

    for (int r = 0; r < N; r++) begin
      guard = 0;
      while (!out_valid && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      nstall = (r == stall_row) ? stall_cyc : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      held = out_row;
      out_ready = 1'b0;
      for (int s = 0; s < nstall; s++) begin
        @(negedge clk);
        check($sformatf("%s_hold_row%0d", name, r), out_row, held);
        check($sformatf("%s_hold_valid%0d", name, r), out_valid, 1'b1);
      end
      for (int j = 0; j < N; j++) exp_row[j*AW +: AW] = AW'(mc[r][j]);
      check($sformatf("%s_row%0d", name, r), out_row, exp_row);
      check($sformatf("%s_last%0d", name, r), out_last, (r == N-1));
      check($sformatf("%s_in_ready%0d", name, r), in_ready, 1'b0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    check({name, "_end_valid"}, out_valid, 1'b0);
    check({name, "_end_busy"}, busy, 1'b0);
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start = 1'b0; k_len = '0; acc_keep = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a_vec = '0; b_vec = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) mc[i][j] = 0;

    #12;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_row", out_row, '0);
    @(negedge clk);
    reset = 1'b1;

    load_identity();
    run_job(4, 1'b0, 0, -1, 0, 1'b0, "ident");
    run_job(4, 1'b0, 1, 1, 3, 1'b0, "bp");
    run_job(4, 1'b1, 0, -1, 0, 1'b0, "accum");
    run_job(4, 1'b0, 0, -1, 0, 1'b0, "reclear");
    run_job(4, 1'b0, 0, -1, 0, 1'b1, "midstart");

    load_const(-128, -128);
    run_job(16, 1'b0, 0, -1, 0, 1'b0, "ext_pos");
    load_const(-128, 127);
    run_job(16, 1'b0, 0, -1, 0, 1'b0, "ext_neg");

    run_job(0, 1'b0, 0, -1, 0, 1'b0, "klen0");

    load_random();
    run_job(20, 1'b0, 0, -1, 0, 1'b0, "clamp");

    for (int t = 0; t < 6; t++) begin
      load_random();
      run_job(int'($urandom_range(1, KMAX)), 1'($urandom_range(0, 1)), 2,
              int'($urandom_range(0, N-1)), 2, 1'b0, $sformatf("rand%0d", t));
    end

    // reset in the middle of LOAD after two accepted beats
    load_identity();
    @(negedge clk);
    start = 1'b1; k_len = 4; acc_keep = 1'b0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; drive_beat(0);
    @(negedge clk);
    drive_beat(1);
    @(negedge clk);
    in_valid = 1'b0;
    check("midload_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_last", out_last, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_out_row", out_row, '0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) mc[i][j] = 0;
    run_job(4, 1'b1, 0, -1, 0, 1'b0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_mac_array.md
SYSTOLIC_MAC_ARRAY -- requirements
Module: systolic_mac_array

Interface
REQ-001 SHALL have parameter DW, default 8, signed element width of A and B.
REQ-002 SHALL have parameter N, default 4, array dimension (N x N PEs); N >= 2 SHALL be required.
REQ-003 SHALL have parameter KMAX, default 16, maximum inner dimension per job.
REQ-004 SHALL have parameter AW, default 2*DW+clog2(KMAX), signed accumulator width.
REQ-005 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port: start  in  1  one-cycle job request, sampled only in IDLE.
REQ-008 SHALL have port: k_len  in  clog2(KMAX+1)  beats per job, sampled with start; values above KMAX clamp to KMAX.
REQ-009 SHALL have port: acc_keep  in  1  sampled with start; 1 = accumulate onto previous results, 0 = clear accumulators.
REQ-010 SHALL have port: in_valid  in  1 and in_ready  out  1  input beat handshake.
REQ-011 SHALL have port: a_vec  in  N*DW  column k of A, element i at bits [i*DW +: DW].
REQ-012 SHALL have port: b_vec  in  N*DW  row k of B, element j at bits [j*DW +: DW].
REQ-013 SHALL have port: out_valid  out  1 and out_ready  in  1  result row handshake.
REQ-014 SHALL have port: out_row  out  N*AW  row r of C, element j at bits [j*AW +: AW].
REQ-015 SHALL have port: out_last  out  1  high with out_valid on row N-1.
REQ-016 SHALL have port: busy  out  1  high in any state other than IDLE.

Function
REQ-017 SHALL compute C = A x B, output-stationary: PE(i,j) holds accumulator C[i][j].
REQ-018 SHALL implement FSM IDLE -> LOAD -> FLUSH -> DRAIN -> IDLE.
REQ-019 IDLE: start=1 with k_len>0 -> LOAD; start=1 with k_len=0 -> DRAIN directly; start clears skew and PE pass registers, and clears accumulators when acc_keep=0.
REQ-020 LOAD: in_ready=1; beat accepted on in_valid&in_ready; array advances only on accepted beats (in_valid=0 stalls entire array and skew, no state change).
REQ-021 Skew: row i of A and column j of B SHALL be delayed i and j enabled cycles; beat k reaches PE(i,j) on enabled cycle k+i+j.
REQ-022 PE: on each enabled edge acc <= acc + a*b (signed, full 2*DW product, sign-extended to AW, two's-complement wrap); a passes right, b passes down through one register each.
REQ-023 Edge accepting beat k_len-1 SHALL move LOAD -> FLUSH.
REQ-024 FLUSH: array enabled every cycle with zero injected at inputs, for exactly 2N-2 cycles, then -> DRAIN; in_ready=0.
REQ-025 first out_valid SHALL be asserted 2N-1 edges after the edge accepting the last beat.
REQ-026 DRAIN: out_row = row r, r from 0 to N-1; r advances on out_valid&out_ready; out_row, out_last stable while out_ready=0.
REQ-027 Transfer of row N-1 SHALL return to IDLE, out_valid low next cycle; accumulators retain values.
REQ-028 start outside IDLE SHALL be ignored; in_valid outside LOAD SHALL be ignored.
REQ-029 out_valid=0 and out_last=0 outside DRAIN.

Reset
REQ-030 reset low SHALL immediately force IDLE, in_ready=0, out_valid=0, out_last=0, busy=0, out_row=0, all accumulators, skew and pass registers, row and beat counters to 0, from any state including mid-LOAD or mid-DRAIN.
REQ-031 after reset release, first start SHALL behave as a fresh job regardless of acc_keep.

Verification (N=4, DW=8, KMAX=16)
REQ-032 Identity: k_len=4, acc_keep=0, beat k a_vec=e_k, b_vec=[4k+1,4k+2,4k+3,4k+4] -> rows [1,2,3,4],[5,6,7,8],[9,10,11,12],[13,14,15,16], out_last on 4th, out_valid 7 edges after last beat.
REQ-033 Signed extremes: k_len=16, all a=-128, all b=-128 -> every C element 262144; all a=-128, b=127 -> every element -260096.
REQ-034 Backpressure: in_valid toggled every other cycle during LOAD, out_ready low 3 cycles on row 1 -> results identical to REQ-032, row 1 held stable, no row skipped or repeated.
REQ-035 Accumulate: REQ-032 job, then same data with acc_keep=1 -> rows doubled ([2,4,6,8] ...); third job acc_keep=0 -> back to single values.
REQ-036 Boundaries: k_len=0, acc_keep=0 -> four zero rows immediately; start pulsed during LOAD ignored; k_len=20 -> exactly 16 beats accepted.
REQ-037 Reset mid-LOAD after 2 beats -> all outputs 0, busy=0 within same cycle; following REQ-032 job correct.
